id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the MIPS pipeline. It sits directly downstream of the register file. It captures the register-file read data (A, B), decoded register indices, sign-extended immediate and control bits into the ID/EX latch once per cycle. It also detects load-use hazards, inserting a bubble and stalling upstream, and honours flush and hold requests from later stages.

## Interface
- `STALL_CNT_W`, default 16: width of the saturating bubble counter.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `id_valid` input 1: decode slot holds a real instruction.
- `id_a`, `id_b` input 32 each: register-file read data for rs, rt.
- `id_rs`, `id_rt`, `id_rd` input 5 each: decoded register indices.
- `id_imm` input 32: sign-extended immediate.
- `id_uses_rt` input 1: instruction reads rt as a source.
- `id_ctrl` input CTRL_W (10): {regwrite, memtoreg, memread, memwrite, branch, alusrc, regdst, aluop[1:0], jump}.
- `flush_i` input 1: branch/jump resolved taken; kill the ID/EX contents.
- `hold_i` input 1: downstream busy; freeze the ID/EX latch.
- `wb_regwrite` input 1: writeback port write enable (used only for bypass).
- `wb_rd` input 5: writeback port destination (used only for bypass).
- `wb_data` input 32: writeback port data (used only for bypass).
- `stall_o` output 1: upstream (PC, IF/ID) must hold this cycle.
- `ex_valid` output 1: ID/EX slot valid.
- `ex_a`, `ex_b`, `ex_imm` output 32 each: latched operands.
- `ex_rs`, `ex_rt`, `ex_rd` output 5 each: latched indices.
- `ex_ctrl` output CTRL_W: latched control; all-zero NOP when `ex_valid`=0.
- `bubble_cnt` output STALL_CNT_W: count of hazard bubbles inserted since reset; saturating.

## Operation
Per-edge update. First matching case wins:
1. `!rst_n`: `ex_valid`=0, all `ex_*` data outputs=0, `ex_ctrl`=NOP, `bubble_cnt`=0.
2. `flush_i`: `ex_valid`=0, `ex_ctrl`=NOP, data fields don't-care (zeroed).
3. `hold_i`: all `ex_*` outputs retain their values.
4. Load-use hazard: `ex_valid`=0, `ex_ctrl`=NOP, `bubble_cnt`+=1, saturating at all-ones.
5. Otherwise: load the `id_*` inputs; `ex_valid`=`id_valid`; `ex_ctrl`=`id_ctrl` if `id_valid`, else NOP.

Load-use hazard condition, combinational:
- `ex_valid` & `ex_ctrl.memread` & `id_valid` & `ex_rt`≠0, and
- either `ex_rt`==`id_rs`, or (`id_uses_rt` & `ex_rt`==`id_rt`).

Stall output:
- `stall_o` = hazard | `hold_i`.
- `stall_o` is forced to 0 when `flush_i`=1, because upstream is being redirected anyway.

Register 0 never causes a hazard.

## Timing
- Latency: 1 cycle from the `id_*` inputs to the `ex_*` outputs.
- `stall_o` is combinational from the current `ex_*` state and `id_*` inputs, valid in the same cycle.
- A load-use hazard yields exactly one bubble. On the next cycle `ex_valid`=0, so the hazard clears and the held instruction loads.
- `hold_i` and a hazard in the same cycle: hold wins; no bubble is counted.
- `flush_i` and `hold_i` together: flush wins.
- Reset asserted mid-stall: outputs reach their reset values on that edge. `stall_o` is 0 during reset.

## Configuration
- `ID_EX_WB_BYPASS_EN` defined:
  - When `wb_regwrite` & `wb_rd`≠0 & `wb_rd`==`id_rs`, `ex_a` loads `wb_data` instead of `id_a`.
  - Likewise for `id_rt`/`ex_b`.
  - This covers same-cycle write/read through the register file.
- Not defined:
  - `id_a`/`id_b` are latched verbatim.
  - The `wb_*` ports are present but unused.

## Structure
- Shared package `pipe_pkg` holds:
  - `CTRL_W`, the control bit positions, and `ALUOP_*` encodings.
  - `CTRL_NOP` (all-zero).
- Sub-module `load_use_detect` is purely combinational: inputs are the ex memread/rt/valid and the id rs/rt/uses_rt/valid; output is `hazard`.

## Test plan
- Reset:
  - Stimulus: `rst_n`=0 for 2 cycles with random `id_*`.
  - Required: `ex_valid`=0, `ex_ctrl`=0, `bubble_cnt`=0, `stall_o`=0.
- Pass-through:
  - Stimulus: `id_a`=0x12345678, `id_rs`=3, `id_valid`=1.
  - Required: next cycle `ex_a`=0x12345678, `ex_rs`=3, `ex_valid`=1.
- Load-use on rs:
  - Stimulus: lw $t1 (`ex_rt`=9, memread) followed by add using rs=9.
  - Required: `stall_o`=1 for one cycle, one NOP cycle, then the add latches; `bubble_cnt`=1.
- Load-use on rt:
  - Stimulus: rt=9 with `id_uses_rt`=0.
  - Required: no stall. With `ex_rt`=0 and rs=0: no stall.
- Flush:
  - Stimulus: `flush_i`=1 concurrent with a hazard and `hold_i`.
  - Required: `ex_valid`=0, `stall_o`=0, `bubble_cnt` unchanged.
- Bypass, with `ID_EX_WB_BYPASS_EN` defined:
  - Stimulus: `wb_rd`=5, `wb_data`=0xDEAD, `id_rs`=5, `id_a`=0.
  - Required: `ex_a`=0xDEAD.
  - With the macro undefined: `ex_a`=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control word layout, ALU op encodings, NOP
// control word and a register-index match helper.
package pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 10;

  // Bit positions inside the control word
  localparam int unsigned CTRL_REGWRITE = 9;
  localparam int unsigned CTRL_MEMTOREG = 8;
  localparam int unsigned CTRL_MEMREAD  = 7;
  localparam int unsigned CTRL_MEMWRITE = 6;
  localparam int unsigned CTRL_BRANCH   = 5;
  localparam int unsigned CTRL_ALUSRC   = 4;
  localparam int unsigned CTRL_REGDST   = 3;
  localparam int unsigned CTRL_ALUOP_HI = 2;
  localparam int unsigned CTRL_ALUOP_LO = 1;
  localparam int unsigned CTRL_JUMP     = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic [1:0] aluop;
    logic       jump;
  } ctrl_t;

  // True when a producer index names the same non-zero register as a consumer
  function automatic logic reg_match(input logic [REG_W-1:0] prod,
                                     input logic [REG_W-1:0] cons);
    return (prod != '0) && (prod == cons);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Ports: i_ex_valid/i_ex_memread/i_ex_rt describe the instruction in EX;
//        i_id_valid/i_id_rs/i_id_rt/i_id_uses_rt describe the one in ID;
//        o_hazard is high when ID must wait one cycle for the load data.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             i_ex_valid,
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  output logic             o_hazard
);

  logic w_load_in_ex;
  logic w_src_hit;

  assign w_load_in_ex = i_ex_valid & i_ex_memread & i_id_valid;
  // $0 is filtered inside reg_match
  assign w_src_hit    = reg_match(i_ex_rt, i_id_rs) |
                        (i_id_uses_rt & reg_match(i_ex_rt, i_id_rt));
  assign o_hazard     = w_load_in_ex & w_src_hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline latch with load-use bubble insertion, flush and hold.
// Ports: clk, rst_n (synchronous, active low); id_* decode inputs;
//        flush_i kills the latch, hold_i freezes it; wb_* writeback bypass;
//        stall_o holds upstream; ex_* latched outputs; bubble_cnt counts
//        inserted bubbles (saturating).
// Config: define ID_EX_WB_BYPASS_EN to forward wb_data into ex_a/ex_b when
//         the writeback destination matches id_rs/id_rt.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [DATA_W-1:0]      id_a,
  input  logic [DATA_W-1:0]      id_b,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rt,
  input  logic [REG_W-1:0]       id_rd,
  input  logic [DATA_W-1:0]      id_imm,
  input  logic                   id_uses_rt,
  input  logic [CTRL_W-1:0]      id_ctrl,
  input  logic                   flush_i,
  input  logic                   hold_i,
  input  logic                   wb_regwrite,
  input  logic [REG_W-1:0]       wb_rd,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   stall_o,
  output logic                   ex_valid,
  output logic [DATA_W-1:0]      ex_a,
  output logic [DATA_W-1:0]      ex_b,
  output logic [DATA_W-1:0]      ex_imm,
  output logic [REG_W-1:0]       ex_rs,
  output logic [REG_W-1:0]       ex_rt,
  output logic [REG_W-1:0]       ex_rd,
  output logic [CTRL_W-1:0]      ex_ctrl,
  output logic [STALL_CNT_W-1:0] bubble_cnt
);

  logic                   r_valid;
  logic [DATA_W-1:0]      r_a, r_b, r_imm;
  logic [REG_W-1:0]       r_rs, r_rt, r_rd;
  logic [CTRL_W-1:0]      r_ctrl;
  logic [STALL_CNT_W-1:0] r_bubble_cnt;

  ctrl_t                  w_ex_ctrl;
  logic                   w_hazard;
  logic [DATA_W-1:0]      w_a_next, w_b_next;

  assign w_ex_ctrl = ctrl_t'(r_ctrl);

  load_use_detect u_load_use_detect (
    .i_ex_valid   (r_valid),
    .i_ex_memread (w_ex_ctrl.memread),
    .i_ex_rt      (r_rt),
    .i_id_valid   (id_valid),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_uses_rt (id_uses_rt),
    .o_hazard     (w_hazard)
  );

  // Operand select: same-cycle writeback forwarding when enabled
`ifdef ID_EX_WB_BYPASS_EN
  assign w_a_next = (wb_regwrite && reg_match(wb_rd, id_rs)) ? wb_data : id_a;
  assign w_b_next = (wb_regwrite && reg_match(wb_rd, id_rt)) ? wb_data : id_b;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_regwrite, wb_rd, wb_data};
  assign w_a_next    = id_a;
  assign w_b_next    = id_b;
`endif

  // Upstream is redirected on flush, and nothing stalls while in reset
  assign stall_o = rst_n & ~flush_i & (w_hazard | hold_i);

  // ID/EX latch: reset > flush > hold > bubble > load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_ctrl       <= CTRL_NOP;
      r_bubble_cnt <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_ctrl  <= CTRL_NOP;
    end else if (hold_i) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      // Bubble: the ID instruction stays upstream and retries next cycle
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_ctrl  <= CTRL_NOP;
      if (r_bubble_cnt != '1) begin
        r_bubble_cnt <= r_bubble_cnt + STALL_CNT_W'(1);
      end
    end else begin
      r_valid <= id_valid;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_imm   <= id_imm;
      r_rs    <= id_rs;
      r_rt    <= id_rt;
      r_rd    <= id_rd;
      r_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  assign ex_valid   = r_valid;
  assign ex_a       = r_a;
  assign ex_b       = r_b;
  assign ex_imm     = r_imm;
  assign ex_rs      = r_rs;
  assign ex_rt      = r_rt;
  assign ex_rd      = r_rd;
  assign ex_ctrl    = r_ctrl;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage. The counter is built 2 bits
// wide so saturation is reachable in a few bubbles.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int unsigned CNT_W = 2;

  localparam logic [CTRL_W-1:0] C_LW =
    CTRL_W'((1 << CTRL_REGWRITE) | (1 << CTRL_MEMTOREG) |
            (1 << CTRL_MEMREAD)  | (1 << CTRL_ALUSRC) |
            (int'(ALUOP_ADD) << CTRL_ALUOP_LO));
  localparam logic [CTRL_W-1:0] C_ADD =
    CTRL_W'((1 << CTRL_REGWRITE) | (1 << CTRL_REGDST) |
            (int'(ALUOP_FUNCT) << CTRL_ALUOP_LO));
  localparam logic [CTRL_W-1:0] C_BEQ =
    CTRL_W'((1 << CTRL_BRANCH) | (int'(ALUOP_SUB) << CTRL_ALUOP_LO) |
            (0 << CTRL_ALUOP_HI) | (0 << CTRL_MEMWRITE) | (0 << CTRL_JUMP));

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_uses_rt, flush_i, hold_i, wb_regwrite;
  logic [DATA_W-1:0] id_a, id_b, id_imm, wb_data;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd, wb_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              stall_o, ex_valid;
  logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
  logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.STALL_CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_a(id_a), .id_b(id_b),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl), .flush_i(flush_i),
    .hold_i(hold_i), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .stall_o(stall_o), .ex_valid(ex_valid), .ex_a(ex_a),
    .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [REG_W-1:0] rs,
                       input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd,
                       input logic urt, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
    id_ctrl = c; id_a = a; id_b = b; id_imm = 32'h4;
    #1;
  endtask

  // lw into $9 then a consumer of $9: exactly one bubble
  task automatic make_bubble(input logic [31:0] exp_cnt, input string tag);
    drive(1'b1, 5'd2, 5'd9, 5'd0, 1'b0, C_LW, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd9, 5'd10, 5'd11, 1'b1, C_ADD, 32'h11, 32'h22);
    check({tag, "_stall"}, 32'(stall_o), 32'd1);
    tick();
    check({tag, "_bubble_valid"}, 32'(ex_valid), 32'd0);
    check({tag, "_cnt"}, 32'(bubble_cnt), exp_cnt);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b1;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    drive(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1,
          CTRL_W'($urandom), $urandom, $urandom);
    tick();
    tick();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_ctrl", 32'(ex_ctrl), 32'd0);
    check("rst_cnt", 32'(bubble_cnt), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_a", ex_a, 32'd0);

    rst_n = 1'b1; hold_i = 1'b0;
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, C_ADD, 32'h12345678, 32'hCAFE);
    tick();
    check("pt_a", ex_a, 32'h12345678);
    check("pt_b", ex_b, 32'hCAFE);
    check("pt_rs", 32'(ex_rs), 32'd3);
    check("pt_valid", 32'(ex_valid), 32'd1);
    check("pt_ctrl", 32'(ex_ctrl), 32'(C_ADD));

    // Load-use on rs, then the held add latches
    make_bubble(32'd1, "lu_rs");
    check("lu_rs_stall_clear", 32'(stall_o), 32'd0);
    check("lu_rs_add_valid", 32'(ex_valid), 32'd1);
    check("lu_rs_add_rs", 32'(ex_rs), 32'd9);
    check("lu_rs_add_a", ex_a, 32'h11);

    // rt match only counts when rt is a source
    drive(1'b1, 5'd2, 5'd9, 5'd0, 1'b0, C_LW, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd1, 5'd9, 5'd12, 1'b0, C_ADD, 32'h1, 32'h2);
    check("lu_rt_unused", 32'(stall_o), 32'd0);
    id_uses_rt = 1'b1; #1;
    check("lu_rt_used", 32'(stall_o), 32'd1);
    id_uses_rt = 1'b0; #1;
    tick();
    check("lu_rt_cnt", 32'(bubble_cnt), 32'd1);

    // Load into $0 never hazards
    drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, C_LW, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, C_ADD, 32'h1, 32'h2);
    check("r0_stall", 32'(stall_o), 32'd0);
    tick();
    check("r0_valid", 32'(ex_valid), 32'd1);

    // Hold with a pending hazard: latch frozen, no bubble counted
    drive(1'b1, 5'd2, 5'd9, 5'd0, 1'b0, C_LW, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd9, 5'd10, 5'd11, 1'b1, C_ADD, 32'h11, 32'h22);
    hold_i = 1'b1; #1;
    check("hold_stall", 32'(stall_o), 32'd1);
    tick();
    check("hold_valid", 32'(ex_valid), 32'd1);
    check("hold_ctrl", 32'(ex_ctrl), 32'(C_LW));
    check("hold_cnt", 32'(bubble_cnt), 32'd1);

    // Flush beats hold and hazard
    flush_i = 1'b1; #1;
    check("flush_stall", 32'(stall_o), 32'd0);
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_ctrl", 32'(ex_ctrl), 32'd0);
    check("flush_cnt", 32'(bubble_cnt), 32'd1);
    flush_i = 1'b0; hold_i = 1'b0;

    // Invalid slot loads a NOP control word
    drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, C_BEQ, 32'h5, 32'h6);
    tick();
    check("inv_valid", 32'(ex_valid), 32'd0);
    check("inv_ctrl", 32'(ex_ctrl), 32'd0);

    // Saturating counter (2 bits)
    make_bubble(32'd2, "sat2");
    make_bubble(32'd3, "sat3");
    make_bubble(32'd3, "sat_hold");

    // Writeback bypass
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD;
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, C_ADD, 32'h0, 32'h77);
    tick();
`ifdef ID_EX_WB_BYPASS_EN
    check("byp_a", ex_a, 32'hDEAD);
    check("byp_b", ex_b, 32'hDEAD);
`else
    check("byp_a", ex_a, 32'h0);
    check("byp_b", ex_b, 32'h77);
`endif
    wb_rd = 5'd0;
    drive(1'b1, 5'd0, 5'd7, 5'd6, 1'b1, C_ADD, 32'h55, 32'h66);
    tick();
    check("byp_r0_a", ex_a, 32'h55);
    wb_regwrite = 1'b0;

    // Reset during a stall
    drive(1'b1, 5'd2, 5'd9, 5'd0, 1'b0, C_LW, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd9, 5'd10, 5'd11, 1'b1, C_ADD, 32'h11, 32'h22);
    rst_n = 1'b0; #1;
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    tick();
    check("mid_rst_valid", 32'(ex_valid), 32'd0);
    check("mid_rst_cnt", 32'(bubble_cnt), 32'd0);
    check("mid_rst_rt", 32'(ex_rt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
